// File: rtl/pair_feeder.sv
// -----------------------------------------------------------------------------
// pair_feeder
//
// Sequential driver for the `compare` min-select cell in the disparity search
// path. Buffers framed (cost, disparity) candidates in a small FIFO, frames the
// comparator with startsig/finalstart pulses, reduces each frame to a single
// minimum by feeding candidate-vs-accumulator pairs through the external
// comparator, and emits the winner as a one-cycle result.
//
// Optional feature macro: PAIR_FEEDER_SELFCHECK_EN
//   defined   : the comparator result is checked locally in SETTLE; any
//               disagreement sets the sticky `err` output until `rst`.
//   undefined : no check logic, `err` is tied to 0.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid/in_ready        candidate handshake (in_ready = FIFO not full)
//   in_cost/in_idx/in_last   candidate cost, disparity, end-of-frame flag
//   startsig, finalstart     comparator return-to-waiting / enter-working pulses
//   in1/inp1, in2/inp2       comparator operands: candidate, accumulator
//   cmp_out/cmp_outp         comparator result (cost, disparity)
//   res_valid/res_cost/res_idx  one-cycle frame result
//   err                      sticky self-check error
// -----------------------------------------------------------------------------
module pair_feeder #(
   parameter int COST_W = 18,
   parameter int IDX_W  = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [COST_W-1:0] in_cost,
   input  logic [IDX_W-1:0]  in_idx,
   input  logic              in_last,
   output logic              startsig,
   output logic              finalstart,
   output logic [COST_W-1:0] in1,
   output logic [COST_W-1:0] in2,
   output logic [IDX_W-1:0]  inp1,
   output logic [IDX_W-1:0]  inp2,
   input  logic [COST_W-1:0] cmp_out,
   input  logic [IDX_W-1:0]  cmp_outp,
   output logic              res_valid,
   output logic [COST_W-1:0] res_cost,
   output logic [IDX_W-1:0]  res_idx,
   output logic              err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ARM,
      S_LOAD,
      S_FEED,
      S_SETTLE,
      S_DONE
   } state_t;

   // ---------------------------------------------------------------------------
   // Candidate FIFO
   // ---------------------------------------------------------------------------
   logic [COST_W-1:0] fifo_cost_q [DEPTH];
   logic [IDX_W-1:0]  fifo_idx_q  [DEPTH];
   logic              fifo_last_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop;

   logic [COST_W-1:0] head_cost;
   logic [IDX_W-1:0]  head_idx;
   logic              head_last;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(DEPTH));
   // Held low during reset so no candidate is accepted while the FIFO clears.
   assign in_ready   = ~fifo_full & ~rst;
   assign push       = in_valid & in_ready;

   assign head_cost  = fifo_cost_q[rd_ptr_q];
   assign head_idx   = fifo_idx_q[rd_ptr_q];
   assign head_last  = fifo_last_q[rd_ptr_q];

   // NOTE: the storage array has no reset; validity is tracked by count_q and the
   // pointers, so resetting the entries would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_cost_q[wr_ptr_q] <= in_cost;
         fifo_idx_q[wr_ptr_q]  <= in_idx;
         fifo_last_q[wr_ptr_q] <= in_last;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Reduction FSM
   // ---------------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [COST_W-1:0] acc_cost_q, acc_cost_d;
   logic [IDX_W-1:0]  acc_idx_q, acc_idx_d;
   logic              last_q, last_d;
   logic              startsig_q, startsig_d;
   logic              finalstart_q, finalstart_d;
   logic [COST_W-1:0] in1_q, in1_d, in2_q, in2_d;
   logic [IDX_W-1:0]  inp1_q, inp1_d, inp2_q, inp2_d;
   logic              res_valid_q, res_valid_d;
   logic [COST_W-1:0] res_cost_q, res_cost_d;
   logic [IDX_W-1:0]  res_idx_q, res_idx_d;

   // Every output is decoded from the current state and registered, so each
   // pulse appears one cycle after its state and is free of decode glitches.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      acc_cost_d   = acc_cost_q;
      acc_idx_d    = acc_idx_q;
      last_d       = last_q;
      in1_d        = in1_q;
      in2_d        = in2_q;
      inp1_d       = inp1_q;
      inp2_d       = inp2_q;
      res_cost_d   = res_cost_q;
      res_idx_d    = res_idx_q;
      startsig_d   = 1'b0;
      finalstart_d = 1'b0;
      res_valid_d  = 1'b0;
      pop          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) state_d = S_START;
         end
         S_START: begin
            startsig_d = 1'b1;
            state_d    = S_ARM;
         end
         S_ARM: begin
            finalstart_d = 1'b1;
            state_d      = S_LOAD;
         end
         S_LOAD: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               acc_cost_d = head_cost;
               acc_idx_d  = head_idx;
               // A one-candidate frame skips the comparator entirely.
               state_d    = head_last ? S_DONE : S_FEED;
            end
         end
         S_FEED: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               in1_d   = head_cost;
               inp1_d  = head_idx;
               in2_d   = acc_cost_q;
               inp2_d  = acc_idx_q;
               last_d  = head_last;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            // Operands have been stable for this whole cycle; the comparator
            // keeps in2 on ties, so the earliest disparity is retained.
            acc_cost_d = cmp_out;
            acc_idx_d  = cmp_outp;
            state_d    = last_q ? S_DONE : S_FEED;
         end
         S_DONE: begin
            res_valid_d = 1'b1;
            res_cost_d  = acc_cost_q;
            res_idx_d   = acc_idx_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         acc_cost_q   <= '0;
         acc_idx_q    <= '0;
         last_q       <= 1'b0;
         startsig_q   <= 1'b0;
         finalstart_q <= 1'b0;
         in1_q        <= '0;
         in2_q        <= '0;
         inp1_q       <= '0;
         inp2_q       <= '0;
         res_valid_q  <= 1'b0;
         res_cost_q   <= '0;
         res_idx_q    <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         acc_cost_q   <= acc_cost_d;
         acc_idx_q    <= acc_idx_d;
         last_q       <= last_d;
         startsig_q   <= startsig_d;
         finalstart_q <= finalstart_d;
         in1_q        <= in1_d;
         in2_q        <= in2_d;
         inp1_q       <= inp1_d;
         inp2_q       <= inp2_d;
         res_valid_q  <= res_valid_d;
         res_cost_q   <= res_cost_d;
         res_idx_q    <= res_idx_d;
      end
   end

   assign startsig   = startsig_q;
   assign finalstart = finalstart_q;
   assign in1        = in1_q;
   assign in2        = in2_q;
   assign inp1       = inp1_q;
   assign inp2       = inp2_q;
   assign res_valid  = res_valid_q;
   assign res_cost   = res_cost_q;
   assign res_idx    = res_idx_q;

   // ---------------------------------------------------------------------------
   // Optional comparator self-check
   // ---------------------------------------------------------------------------
`ifdef PAIR_FEEDER_SELFCHECK_EN
   logic              err_q, err_d;
   logic              cand_wins;
   logic [COST_W-1:0] exp_cost;
   logic [IDX_W-1:0]  exp_idx;

   always_comb begin
      cand_wins = (in1_q < in2_q);
      exp_cost  = cand_wins ? in1_q  : in2_q;
      exp_idx   = cand_wins ? inp1_q : inp2_q;
      err_d     = err_q;
      if ((state_q == S_SETTLE) && ((cmp_out != exp_cost) || (cmp_outp != exp_idx))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pair_feeder.sv
// -----------------------------------------------------------------------------
// tb_pair_feeder
//
// Directed bench for pair_feeder. A behavioural comparator drives cmp_out /
// cmp_outp from in1/in2. The reference model collects each accepted frame and
// scans it for the earliest minimum; a per-cycle monitor compares every result
// pulse against that queue, and the main sequence pins the model with literal
// expectations (values, pulse counts, latency, reset behaviour).
// -----------------------------------------------------------------------------
module tb_pair_feeder;

   localparam int COST_W = 18;
   localparam int IDX_W  = 8;
   localparam int DEPTH  = 4;
   localparam int LIMIT  = 200;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [COST_W-1:0] in_cost;
   logic [IDX_W-1:0]  in_idx;
   logic              in_last;
   logic              startsig;
   logic              finalstart;
   logic [COST_W-1:0] in1, in2;
   logic [IDX_W-1:0]  inp1, inp2;
   logic [COST_W-1:0] cmp_out;
   logic [IDX_W-1:0]  cmp_outp;
   logic              res_valid;
   logic [COST_W-1:0] res_cost;
   logic [IDX_W-1:0]  res_idx;
   logic              err;

   pair_feeder #(
      .COST_W (COST_W),
      .IDX_W  (IDX_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_cost    (in_cost),
      .in_idx     (in_idx),
      .in_last    (in_last),
      .startsig   (startsig),
      .finalstart (finalstart),
      .in1        (in1),
      .in2        (in2),
      .inp1       (inp1),
      .inp2       (inp2),
      .cmp_out    (cmp_out),
      .cmp_outp   (cmp_outp),
      .res_valid  (res_valid),
      .res_cost   (res_cost),
      .res_idx    (res_idx),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural comparator: in1 only wins when strictly smaller.
   logic force_bad;
   always_comb begin
      cmp_out  = (in1 < in2) ? in1  : in2;
      cmp_outp = (in1 < in2) ? inp1 : inp2;
      if (force_bad) begin
         cmp_out  = in2 ^ 18'd1;
         cmp_outp = inp2;
      end
   end

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [COST_W-1:0] cost;
      logic [IDX_W-1:0]  idx;
   } cand_t;

   cand_t frame_q[$];
   cand_t exp_q[$];
   bit    model_on = 1'b1;

   // Reference model: earliest candidate with the strictly smallest cost.
   task automatic model_accept(input cand_t c, input bit last);
      cand_t best;
      frame_q.push_back(c);
      if (last) begin
         best = frame_q[0];
         foreach (frame_q[i]) if (frame_q[i].cost < best.cost) best = frame_q[i];
         exp_q.push_back(best);
         frame_q.delete();
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int    start_cnt = 0;
   int    fin_cnt = 0;
   int    res_cnt = 0;
   int    notready_cnt = 0;
   int    last_start_cyc = 0;
   int    last_res_cyc = 0;
   cand_t mon_e;

   // Per-cycle compare process.
   always @(negedge clk) begin
      if (!rst) begin
         if (startsig) begin
            start_cnt++;
            last_start_cyc = cyc;
         end
         if (finalstart) fin_cnt++;
         if (startsig || finalstart) check("pulse_overlap", 64'(startsig & finalstart), 64'd0);
         if (!in_ready) notready_cnt++;
         if (res_valid) begin
            res_cnt++;
            last_res_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("res_spurious", 64'(res_valid), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("res_cost_model", 64'(res_cost), 64'(mon_e.cost));
               check("res_idx_model", 64'(res_idx), 64'(mon_e.idx));
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (called at a falling edge)
   // ---------------------------------------------------------------------------
   task automatic push(input int cost, input int idx, input bit last);
      int    guard = 0;
      cand_t c;
      in_valid = 1'b1;
      in_cost  = COST_W'(cost);
      in_idx   = IDX_W'(idx);
      in_last  = last;
      while (!in_ready && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) check("push_accept", 64'(in_ready), 64'd1);
      c.cost = COST_W'(cost);
      c.idx  = IDX_W'(idx);
      if (model_on) model_accept(c, last);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_res(input int target);
      int guard = 0;
      while (res_cnt < target && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      check("res_count", 64'(res_cnt), 64'(target));
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctrl"}, 64'({startsig, finalstart, res_valid, err, in_ready}), 64'd0);
      check({tag, "_in12"}, 64'({in1, in2}), 64'd0);
      check({tag, "_inp12"}, 64'({inp1, inp2}), 64'd0);
      check({tag, "_res"}, 64'({res_cost, res_idx}), 64'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   int s0, f0, r0, nr0, guard;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_cost   = '0;
      in_idx    = '0;
      in_last   = 1'b0;
      force_bad = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 64'(in_ready), 64'd1);

      // Frame A: 500,120,300 -> 120 @ idx 1, result 8 cycles after leaving IDLE
      // (startsig is visible one cycle after that edge, so 7 cycles apart).
      s0 = start_cnt; f0 = fin_cnt; r0 = res_cnt;
      push(500, 0, 1'b0);
      push(120, 1, 1'b0);
      push(300, 2, 1'b1);
      wait_res(r0 + 1);
      check("a_res", 64'({res_cost, res_idx}), 64'({18'd120, 8'd1}));
      check("a_startsig_cnt", 64'(start_cnt - s0), 64'd1);
      check("a_finalstart_cnt", 64'(fin_cnt - f0), 64'd1);
      check("a_latency", 64'(last_res_cyc - last_start_cyc), 64'd7);

      // Ties: 77,77,77 at idx 5,6,7 -> idx 5.
      r0 = res_cnt;
      push(77, 5, 1'b0);
      push(77, 6, 1'b0);
      push(77, 7, 1'b1);
      wait_res(r0 + 1);
      check("tie_res", 64'({res_cost, res_idx}), 64'({18'd77, 8'd5}));

      // One-candidate frame: operands keep the last tie pair (77/7 vs 77/5).
      r0 = res_cnt;
      push(9, 3, 1'b1);
      wait_res(r0 + 1);
      check("one_res", 64'({res_cost, res_idx}), 64'({18'd9, 8'd3}));
      check("one_in12", 64'({in1, in2}), 64'({18'd77, 18'd77}));
      check("one_inp12", 64'({inp1, inp2}), 64'({8'd7, 8'd5}));
      check("one_latency", 64'(last_res_cyc - last_start_cyc), 64'd3);

      // Back-to-back frames, DEPTH+2 candidates pushed without gaps.
      r0 = res_cnt; nr0 = notready_cnt;
      push(40, 10, 1'b0);
      push(25, 11, 1'b0);
      push(60, 12, 1'b1);
      push(15, 20, 1'b0);
      push(7, 21, 1'b0);
      push(7, 22, 1'b1);
      wait_res(r0 + 2);
      check("b2b_second_res", 64'({res_cost, res_idx}), 64'({18'd7, 8'd21}));
      check("b2b_in_ready_dropped", 64'(notready_cnt > nr0), 64'd1);

      // Reset in the first SETTLE of a 4-candidate frame (in1 becomes 40 there).
      push(50, 0, 1'b0);
      push(40, 1, 1'b0);
      push(30, 2, 1'b0);
      push(20, 3, 1'b1);
      guard = 0;
      while (in1 != 18'd40 && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      check("settle_reached", 64'(in1), 64'd40);
      rst = 1'b1;
      frame_q.delete();
      exp_q.delete();
      #1;
      check_outputs_zero("midreset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      s0 = start_cnt; r0 = res_cnt;
      repeat (20) @(negedge clk);
      check("post_reset_fifo_empty", 64'(start_cnt - s0), 64'd0);
      check("post_reset_no_result", 64'(res_cnt - r0), 64'd0);
      push(3, 30, 1'b0);
      push(1, 31, 1'b1);
      wait_res(r0 + 1);
      check("post_reset_res", 64'({res_cost, res_idx}), 64'({18'd1, 8'd31}));

      // Forced wrong comparator: pair 20 vs acc 10 reports 11 -> result 11 @ 40.
      r0 = res_cnt;
      force_bad = 1'b1;
      model_on  = 1'b0;
      exp_q.push_back('{cost: 18'd11, idx: 8'd40});
      push(10, 40, 1'b0);
      push(20, 41, 1'b1);
      wait_res(r0 + 1);
      force_bad = 1'b0;
      model_on  = 1'b1;
      check("forced_res", 64'({res_cost, res_idx}), 64'({18'd11, 8'd40}));
`ifdef PAIR_FEEDER_SELFCHECK_EN
      check("err_set", 64'(err), 64'd1);
      repeat (5) @(negedge clk);
      check("err_sticky", 64'(err), 64'd1);
      rst = 1'b1;
      #1;
      check("err_cleared", 64'(err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
`else
      check("err_tied_low", 64'(err), 64'd0);
      repeat (5) @(negedge clk);
      check("err_still_low", 64'(err), 64'd0);
`endif

      repeat (3) @(negedge clk);
      check("pending_results", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
